instruction_fetch_stage: RTL and testbench

//  IF stage of the MIPS pipeline: owns the PC, drives instructionAddress into the

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/if_id_register.sv | 34 +++
 rtl/instruction_fetch_stage.sv | 96 +++++++++
 tb/tb_instruction_fetch_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path types and constants for the IF stage, decode and hazard units.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
    localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_HOLD,
        PC_BRANCH,
        PC_JUMP
    } nextPcSel_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: bubble beats load; with neither asserted the contents hold.
module if_id_register
    import fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] BUBBLE_WORD = NOP_INSTR
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic                bubble,
    input  logic [INSTR_W-1:0]  instr_in,
    input  logic [ADDR_W-1:0]   pc_plus4_in,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   pc_plus4,
    output logic                valid
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr    <= BUBBLE_WORD;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (bubble) begin
            instr    <= BUBBLE_WORD;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= instr_in;
            pc_plus4 <= pc_plus4_in;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: owns the PC, selects the next PC and feeds the IF/ID register.
module instruction_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000,
    parameter int unsigned        MEM_BYTES = 512,
    parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                branchTaken,
    input  logic [ADDR_W-1:0]   branchTarget,
    input  logic                jump,
    input  logic [ADDR_W-1:0]   jumpTarget,
    input  logic [INSTR_W-1:0]  instructionIn,
    output logic [ADDR_W-1:0]   instructionAddress,
    output logic [INSTR_W-1:0]  ifIdInstruction,
    output logic [ADDR_W-1:0]   ifIdPcPlus4,
    output logic                ifIdValid,
    output logic                fetchFault
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] next_pc;
    logic              out_of_range;
    logic              load;
    logic              bubble;
    nextPcSel_t        sel;

    assign instructionAddress = pc;
    assign pc_plus4           = pc + PC_STEP;
    assign out_of_range       = (pc > LAST_WORD);

    // Branch resolves in EX so it is older than a jump in ID and wins.
    always_comb begin
        sel = PC_SEQ;
        if (branchTaken)
            sel = PC_BRANCH;
        else if (jump)
            sel = PC_JUMP;
        else if (stall)
            sel = PC_HOLD;
    end

    always_comb begin
        next_pc = pc_plus4;
        load    = 1'b0;
        bubble  = 1'b0;
        unique case (sel)
            PC_BRANCH: begin
                next_pc = word_align(branchTarget);
                bubble  = 1'b1;
            end
            PC_JUMP: begin
                next_pc = word_align(jumpTarget);
                bubble  = 1'b1;
            end
            PC_HOLD: next_pc = pc;
            PC_SEQ: begin
                load   = !out_of_range;
                bubble = out_of_range;
            end
            default: next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            fetchFault <= 1'b0;
        end else begin
            pc <= next_pc;
            if (sel == PC_SEQ && out_of_range)
                fetchFault <= 1'b1;
        end
    end

    if_id_register #(
        .BUBBLE_WORD (NOP_INSTR)
    ) u_if_id (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .bubble      (bubble),
        .instr_in    (instructionIn),
        .pc_plus4_in (pc_plus4),
        .instr       (ifIdInstruction),
        .pc_plus4    (ifIdPcPlus4),
        .valid       (ifIdValid)
    );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage with a combinational 512-byte memory model.
module tb_instruction_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branchTaken = 1'b0;
    logic [31:0] branchTarget = '0;
    logic        jump = 1'b0;
    logic [31:0] jumpTarget = '0;
    logic [31:0] instructionIn;
    logic [31:0] instructionAddress;
    logic [31:0] ifIdInstruction;
    logic [31:0] ifIdPcPlus4;
    logic        ifIdValid;
    logic        fetchFault;

    logic [31:0] mem [0:127];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        valid;
        logic        fault;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pp4;
    logic        m_valid;
    logic        m_fault;

    int checks = 0;
    int errors = 0;

    instruction_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .MEM_BYTES (512),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .stall              (stall),
        .branchTaken        (branchTaken),
        .branchTarget       (branchTarget),
        .jump               (jump),
        .jumpTarget         (jumpTarget),
        .instructionIn      (instructionIn),
        .instructionAddress (instructionAddress),
        .ifIdInstruction    (ifIdInstruction),
        .ifIdPcPlus4        (ifIdPcPlus4),
        .ifIdValid          (ifIdValid),
        .fetchFault         (fetchFault)
    );

    always #5 clock = ~clock;

    assign instructionIn = (instructionAddress > 32'd508) ? 32'hDEAD_BEEF
                                                          : mem[instructionAddress[8:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a > 32'd508)
            return 32'hDEAD_BEEF;
        return mem[a[8:2]];
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pp4   = 32'h0;
        m_valid = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic compare_now(input string tag, input exp_t e);
        check({tag, ".addr"},  instructionAddress, e.addr);
        check({tag, ".instr"}, ifIdInstruction,    e.instr);
        check({tag, ".pp4"},   ifIdPcPlus4,        e.pp4);
        check({tag, ".valid"}, {31'b0, ifIdValid},  {31'b0, e.valid});
        check({tag, ".fault"}, {31'b0, fetchFault}, {31'b0, e.fault});
    endtask

    // One clock edge: predict the post-edge state, queue it, then compare after the edge.
    task automatic step(input string tag, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt, input logic st);
        exp_t e;
        exp_t got;
        branchTaken  = br;
        branchTarget = bt;
        jump         = jp;
        jumpTarget   = jt;
        stall        = st;
        if (br || jp) begin
            m_pc    = br ? {bt[31:2], 2'b00} : {jt[31:2], 2'b00};
            m_instr = 32'h0;
            m_pp4   = 32'h0;
            m_valid = 1'b0;
        end else if (!st) begin
            if (m_pc > 32'd508) begin
                m_instr = 32'h0;
                m_pp4   = 32'h0;
                m_valid = 1'b0;
                m_fault = 1'b1;
            end else begin
                m_instr = mem_word(m_pc);
                m_pp4   = m_pc + 32'd4;
                m_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end
        e = '{addr: m_pc, instr: m_instr, pp4: m_pp4, valid: m_valid, fault: m_fault};
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        compare_now(tag, got);
        branchTaken = 1'b0;
        jump        = 1'b0;
        stall       = 1'b0;
    endtask

    task automatic apply_reset(input string tag);
        exp_t e;
        reset = 1'b1;
        #1;
        model_reset();
        e = '{addr: 32'h0, instr: 32'h0, pp4: 32'h0, valid: 1'b0, fault: 1'b0};
        compare_now(tag, e);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem[0] = 32'h0108_0020;
        for (int unsigned i = 1; i < 128; i++)
            mem[i] = 32'h2400_0000 + i * 32'h0001_0003;

        // 1: free-running fetch from reset
        apply_reset("rst0");
        step("t1e1", 0, '0, 0, '0, 0);
        check("t1_word0", ifIdInstruction, 32'h0108_0020);
        step("t1e2", 0, '0, 0, '0, 0);
        step("t1e3", 0, '0, 0, '0, 0);
        step("t1e4", 0, '0, 0, '0, 0);
        check("t1_pc16", instructionAddress, 32'd16);

        // 2: stall at PC=8
        apply_reset("rst1");
        step("t2a", 0, '0, 0, '0, 0);
        step("t2b", 0, '0, 0, '0, 0);
        step("t2s1", 0, '0, 0, '0, 1);
        step("t2s2", 0, '0, 0, '0, 1);
        check("t2_hold_pc", instructionAddress, 32'd8);
        check("t2_hold_pp4", ifIdPcPlus4, 32'd8);
        step("t2r", 0, '0, 0, '0, 0);
        check("t2_resume", ifIdPcPlus4, 32'd12);

        // 3: branch overrides stall
        step("t3br", 1, 32'h1B8, 0, '0, 1);
        check("t3_pc", instructionAddress, 32'h1B8);
        step("t3f", 0, '0, 0, '0, 0);
        check("t3_word", ifIdInstruction, mem[32'h1B8 >> 2]);

        // 4: branch beats jump; jump target alignment
        step("t4bj", 1, 32'h20, 1, 32'h40, 0);
        check("t4_pc_branch", instructionAddress, 32'h20);
        step("t4j", 0, '0, 1, 32'h43, 0);
        check("t4_pc_jump", instructionAddress, 32'h40);

        // 5: out-of-range fetch, sticky fault, recovery, and PC wrap
        step("t5j", 0, '0, 1, 32'h1F8, 0);
        step("t5a", 0, '0, 0, '0, 0);
        step("t5b", 0, '0, 0, '0, 0);
        check("t5_pc200", instructionAddress, 32'h200);
        step("t5oor", 0, '0, 0, '0, 0);
        check("t5_fault", {31'b0, fetchFault}, 32'd1);
        step("t5rec", 0, '0, 1, 32'h0, 0);
        step("t5f", 0, '0, 0, '0, 0);
        check("t5_resume_valid", {31'b0, ifIdValid}, 32'd1);
        step("t5wrapbr", 1, 32'hFFFF_FFFC, 0, '0, 0);
        step("t5wrap", 0, '0, 0, '0, 0);
        check("t5_wrap_pc", instructionAddress, 32'h0);

        // 6: asynchronous reset in mid-cycle while a jump is requested
        step("t6pre", 0, '0, 0, '0, 0);
        jump       = 1'b1;
        jumpTarget = 32'h100;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_now("t6async", '{addr: 32'h0, instr: 32'h0, pp4: 32'h0, valid: 1'b0, fault: 1'b0});
        @(posedge clock);
        #1;
        check("t6_jump_ignored", instructionAddress, 32'h0);
        reset = 1'b0;
        jump  = 1'b0;
        step("t6f", 0, '0, 0, '0, 0);
        check("t6_first_word", ifIdInstruction, 32'h0108_0020);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
